// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: frame limits, receiver state encoding and word-length clamp shared by the UART blocks.
package uart_rx_pkg;

    localparam int UART_MIN_BITS = 5;
    localparam int UART_MAX_BITS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BREAK
    } rx_state_t;

    function automatic logic [4:0] clamp_bits(input logic [4:0] b);
        return b < 5'(UART_MIN_BITS) ? 5'(UART_MIN_BITS) :
               b > 5'(UART_MAX_BITS) ? 5'(UART_MAX_BITS) : b;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-word outputs of the UART receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 16
);
    import uart_rx_pkg::*;

    logic                  rx;
    logic [4:0]            bits_per_word;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  parity_en;
    logic                  parity_evan_odd;
    logic                  two_stop_bit;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output rx, bits_per_word, clk_div, parity_en, parity_evan_odd, two_stop_bit,
        input  data_out, valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx, bits_per_word, clk_div, parity_en, parity_evan_odd, two_stop_bit,
        output data_out, valid, parity_err, frame_err, busy
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable bit-period down-counter; expire marks count==1 and reloads value.
module uart_baud_cnt
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;

    assign expire = en && cnt == WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (en)
            cnt <= expire ? value : cnt - WIDTH'(1);
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver; synchronises rx, samples each bit at its mid-point and
// delivers a right-aligned word with parity/frame flags on a one-cycle valid strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic     clk,
    input logic     rst,
    uart_rx_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    rx_state_t              state;
    logic [4:0]             nbits;
    logic [4:0]             idx;
    logic [DIV_WIDTH-1:0]   div_l;
    logic                   par_en_l;
    logic                   par_odd_l;
    logic                   two_stop_l;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   par_acc;
    logic                   perr_p;
    logic                   ferr_p;
    logic                   start;
    logic                   en;
    logic                   expire;
    logic [DIV_WIDTH-1:0]   cnt_val;

    assign rxs     = sync[SYNC_STAGES-1];
    assign start   = state == S_IDLE && !rxs && bus.clk_div >= DIV_WIDTH'(2);
    assign en      = state != S_IDLE && state != S_BREAK;
    // First expiry lands half a bit after the start edge; every later one a full bit apart.
    assign cnt_val = state == S_IDLE ? bus.clk_div >> 1 : div_l;

    uart_baud_cnt #(.WIDTH(DIV_WIDTH)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .en     (en),
        .value  (cnt_val),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync           <= '1;
            state          <= S_IDLE;
            nbits          <= '0;
            idx            <= '0;
            div_l          <= '0;
            par_en_l       <= 1'b0;
            par_odd_l      <= 1'b0;
            two_stop_l     <= 1'b0;
            shreg          <= '0;
            par_acc        <= 1'b0;
            perr_p         <= 1'b0;
            ferr_p         <= 1'b0;
            bus.data_out   <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], bus.rx};
            bus.valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state      <= S_START;
                    bus.busy   <= 1'b1;
                    nbits      <= clamp_bits(bus.bits_per_word);
                    div_l      <= bus.clk_div;
                    par_en_l   <= bus.parity_en;
                    par_odd_l  <= bus.parity_evan_odd;
                    two_stop_l <= bus.two_stop_bit;
                    idx        <= '0;
                    par_acc    <= 1'b0;
                    perr_p     <= 1'b0;
                    ferr_p     <= 1'b0;
                end
                S_START: if (expire) begin
                    state    <= rxs ? S_IDLE : S_DATA;
                    bus.busy <= !rxs;
                end
                S_DATA: if (expire) begin
                    shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
                    par_acc <= par_acc ^ rxs;
                    idx     <= idx + 5'd1;
                    if (idx + 5'd1 == nbits)
                        state <= par_en_l ? S_PARITY : S_STOP1;
                end
                S_PARITY: if (expire) begin
                    perr_p <= rxs != (par_acc ^ par_odd_l);
                    state  <= S_STOP1;
                end
                S_STOP1, S_STOP2: if (expire) begin
                    if (state == S_STOP1 && two_stop_l) begin
                        ferr_p <= !rxs;
                        state  <= S_STOP2;
                    end else begin
                        // Bits entered at the MSB end; shifting down right-aligns the word.
                        bus.data_out   <= shreg >> (5'(DATA_WIDTH) - nbits);
                        bus.valid      <= 1'b1;
                        bus.parity_err <= perr_p;
                        bus.frame_err  <= ferr_p | !rxs;
                        state          <= rxs ? S_IDLE : S_BREAK;
                        bus.busy       <= !rxs;
                    end
                end
                S_BREAK: if (rxs) begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
